uart_comm: RTL
==============

Name: uart_comm

Overview:
Host-side serial endpoint for the oscilloscope core.
- Receives 8N1 UART bytes on RX and assembles three consecutive bytes into a 24-bit command, presented on cmd/cmd_rdy to the digital core.
- Serializes single-byte responses (resp_data/send_resp) onto TX and reports completion on resp_sent.
- Forms the opposite end of the core's command/response handshake.

Parameters:
- BAUD_DIV, 868, clk cycles per bit (100 MHz / 115200); minimum 4.
- TO_CYCLES, 2_000_000, idle clk cycles between bytes after which a partial command is discarded.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  serial input from host; asynchronous to clk.
- TX  out  1  serial output to host.
- cmd  out  24  assembled command; byte0 in [23:16], byte1 in [15:8], byte2 in [7:0].
- cmd_rdy  out  1  command valid; held high until cleared.
- clr_cmd_rdy  in  1  core acknowledge; clears cmd_rdy.
- resp_data  in  8  response byte.
- send_resp  in  1  one-cycle request to transmit resp_data.
- resp_sent  out  1  one-cycle pulse when the stop bit has finished.
- tx_busy  out  1  high while a frame is in flight.

Behaviour:
Reset (async, rst_n low):
- TX=1; cmd=0; cmd_rdy=0; resp_sent=0; tx_busy=0.
- RX synchronizer flops =1; byte count =0; both FSMs in IDLE.
- Mid-frame reset aborts the frame with no partial outputs.

RX path:
- RX passes through a 2-flop synchronizer plus one history flop; start = synchronized falling edge.
- FSM RX_IDLE -> RX_START: wait BAUD_DIV/2 cycles, then resample.
  - Sample high -> false start, back to RX_IDLE.
  - Sample low -> RX_DATA.
- RX_DATA: 8 samples, each BAUD_DIV cycles apart, LSB first, shifted in.
- RX_STOP: after BAUD_DIV cycles, sample the stop bit.
  - 1 -> byte valid.
  - 0 -> framing error: byte discarded, byte count forced to 0.
  - Either way, return to RX_IDLE immediately (mid-stop), ready for the next start edge.

Command assembly:
- Each valid byte is written into the cmd field selected by byte count (0, 1, 2), then the count increments.
- On the third byte: count -> 0 and cmd_rdy rises on the next clk edge. cmd is updated on the same edge.
- cmd_rdy clears on clr_cmd_rdy, or when a start bit of a new command's first byte is detected.
- Set and clear in the same cycle: set wins.
- cmd bytes are stable while cmd_rdy=1 until the next command's first byte is accepted.
- Timeout: a counter reset on every valid byte. If count≠0 and TO_CYCLES elapse with RX_IDLE, count -> 0. No effect when count=0.

TX path:
- FSM TX_IDLE -> TX_LOAD -> TX_SHIFT.
- send_resp in TX_IDLE latches {1, resp_data, 0} into a 10-bit shifter; tx_busy rises next cycle.
- TX drives shifter[0] for BAUD_DIV cycles per bit, LSB first; 10 bits total.
- After the final stop-bit period: resp_sent pulses for 1 cycle, tx_busy falls, and TX stays 1.
- send_resp while tx_busy=1 is ignored; no queueing.
- Frame length is exactly 10*BAUD_DIV cycles from the latch edge to the resp_sent edge.
- RX and TX are fully independent; full duplex.

Widths:
- Baud counters: clog2(BAUD_DIV) bits.
- Bit counters: 4 bits.
- Timeout counter: clog2(TO_CYCLES+1) bits.

Decomposition:
- Shared package uart_pkg holds:
  - RX state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP).
  - TX state enum (TX_IDLE, TX_LOAD, TX_SHIFT).
  - CMD_BYTES=3 and FRAME_BITS=10.
- Natural sub-module: uart_rcv (synchronizer + RX FSM), outputting rx_byte[7:0], rx_valid and rx_ferr pulses.
- Command assembly, timeout and TX stay in uart_comm.

Test Plan:
- BAUD_DIV=16. Send bytes 0xA5, 0x3C, 0x01 back-to-back -> cmd=0xA53C01, cmd_rdy=1 one clk after the third stop sample; holds until clr_cmd_rdy, then 0 next clk.
- send_resp with resp_data=0x5A -> TX sequence 0,0,1,0,1,1,0,1,0,1, each bit 16 clks; resp_sent pulses once at clk 160; second send_resp at clk 50 is ignored.
- Framing error: 0x11, then 0x22 with stop=0, then 0x33, 0x44, 0x55 -> cmd=0x334455; the bad byte never appears.
- Glitch: RX low for 5 clks -> no byte accepted, RX FSM back to RX_IDLE. Timeout (TO_CYCLES=100): 0x77 then idle 150 clks, then 0x01, 0x02, 0x03 -> cmd=0x010203.
- Same-cycle clr_cmd_rdy and third-byte completion -> cmd_rdy=1. rst_n low mid-TX frame -> TX=1 and tx_busy=0 immediately; no resp_sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the host-side UART command/response endpoint.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT
  } tx_state_t;

  localparam int unsigned CMD_BYTES  = 3;
  localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/uart_rcv.sv
// 8N1 receiver: RX synchronizer, start-edge detection and mid-bit sampling FSM.
// Emits single-cycle rx_valid / rx_ferr at the stop-bit sample and rx_start
// once a start bit has been confirmed at its midpoint.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_start,
  output logic       rx_idle
);

  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] FULL_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  logic            sync1_q, sync2_q, hist_q;
  rx_state_t       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Receiver state, baud/bit counters and data shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: half-bit wait to centre on the start bit, then full-bit steps.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    rx_start = 1'b0;
    case (state_q)
      RX_IDLE: begin
        baud_d = '0;
        if (hist_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          bit_d  = '0;
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d  = RX_DATA;
            rx_start = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (baud_q == FULL_LAST) begin
          baud_d  = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) state_d = RX_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_q == FULL_LAST) begin
          baud_d  = '0;
          state_d = RX_IDLE;
          if (sync2_q) rx_valid = 1'b1;
          else         rx_ferr  = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte = shift_q;
  assign rx_idle = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_comm.sv
// Host-side serial endpoint: assembles 3-byte commands from RX and
// serializes single-byte responses onto TX. RX and TX run independently.
module uart_comm
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 868,
  parameter int unsigned TO_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam int unsigned TW = $clog2(TO_CYCLES + 1);
  localparam logic [BW-1:0] FULL_LAST = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
  localparam logic [1:0]    CNT_LAST  = 2'(CMD_BYTES - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, rx_start, rx_idle;

  uart_rcv #(.BAUD_DIV(BAUD_DIV)) u_rcv (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (RX),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_start (rx_start),
    .rx_idle  (rx_idle)
  );

  logic [23:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;

  // Command register, ready flag, byte count and inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      cnt_q     <= '0;
      to_q      <= '0;
    end else begin
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
    end
  end

  // Clear is evaluated before set so a completing byte wins the same cycle.
  always_comb begin
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    if (clr_cmd_rdy || (rx_start && cnt_q == '0)) cmd_rdy_d = 1'b0;
    if (rx_ferr) begin
      cnt_d = '0;
    end else if (rx_valid) begin
      case (cnt_q)
        2'd0:    cmd_d[23:16] = rx_byte;
        2'd1:    cmd_d[15:8]  = rx_byte;
        default: cmd_d[7:0]   = rx_byte;
      endcase
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        cmd_rdy_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
    if (rx_valid || cnt_q == '0) begin
      to_d = '0;
    end else if (rx_idle) begin
      if (to_q == TO_LAST) begin
        to_d  = '0;
        cnt_d = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  tx_state_t     tx_state_q, tx_state_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          resp_sent_q, resp_sent_d;

  // Transmitter state, shifter and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '1;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // TX_LOAD is the first cycle of the start bit, so SHIFT resumes the baud count at 1.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_shift_d = {1'b1, resp_data, 1'b0};
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        tx_baud_d  = BW'(1);
        tx_state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (tx_baud_q == FULL_LAST) begin
          tx_baud_d  = '0;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d  = TX_IDLE;
            resp_sent_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX        = (tx_state_q == TX_IDLE) ? 1'b1 : tx_shift_q[0];
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign resp_sent = resp_sent_q;

endmodule
